// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_write_arbiter
//  Description : Round-robin arbiter for the single write port of the one-hot
//                selected register bank, with x0/out-of-range filtering and
//                saturating stall/error statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbank_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int ZERO_RO    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         Rin,
    output logic                          we,
    output logic [DEPTH-1:0]              S,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   err_cnt
);

    localparam int                  c_IDW   = $clog2(NUM_REQ);
    localparam logic [c_IDW-1:0]    c_LAST  = c_IDW'(NUM_REQ - 1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [15:0]         c_SAT   = 16'hFFFF;

    logic [c_IDW-1:0]      r_rr_ptr;
    logic [DATA_WIDTH-1:0] r_rin;
    logic                  r_we;
    logic [DEPTH-1:0]      r_s;
    logic [c_IDW-1:0]      r_grant_id;
    logic [15:0]           r_stall_cnt;
    logic [15:0]           r_err_cnt;

    logic                  w_found;
    logic [c_IDW-1:0]      w_win;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_is_zero;
    logic                  w_oob;
    logic [DEPTH-1:0]      w_sel;
    logic                  w_stall;
    logic [c_IDW-1:0]      w_rr_next;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = c_IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_grant   = w_found & ~hold & ~reset;
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

    assign w_addr    = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data    = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_is_zero = (ZERO_RO != 0) && (w_addr == '0);
    assign w_oob     = {1'b0, w_addr} >= c_DEPTH;
    assign w_sel     = DEPTH'(1) << w_addr;
    assign w_stall   = |(req_valid & ~req_ready);
    assign w_rr_next = (w_win == c_LAST) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_rin       <= '0;
            r_we        <= 1'b0;
            r_s         <= '0;
            r_grant_id  <= '0;
            r_stall_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_we <= 1'b0;
            r_s  <= '0;
            if (w_grant) begin
                r_rr_ptr   <= w_rr_next;
                r_grant_id <= w_win;
                // x0 writes are swallowed silently; out-of-range ones are counted.
                if (w_is_zero) begin
                    r_we <= 1'b0;
                end else if (w_oob) begin
                    if (r_err_cnt != c_SAT) r_err_cnt <= r_err_cnt + 16'd1;
                end else begin
                    r_we  <= 1'b1;
                    r_s   <= w_sel;
                    r_rin <= w_data;
                end
            end
            if (w_stall && (r_stall_cnt != c_SAT)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign Rin       = r_rin;
    assign we        = r_we;
    assign S         = r_s;
    assign grant_id  = r_grant_id;
    assign stall_cnt = r_stall_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbank_write_arbiter
//  Description : Scoreboard bench for regbank_write_arbiter (2 requesters,
//                16-entry bank so out-of-range addresses are reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;

    localparam int c_NR = 2;
    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_DP = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 hold;
    logic [c_NR-1:0]      req_valid;
    logic [c_NR*c_AW-1:0] req_addr;
    logic [c_NR*c_DW-1:0] req_data;
    logic [c_NR-1:0]      req_ready;
    logic [c_DW-1:0]      Rin;
    logic                 we;
    logic [c_DP-1:0]      S;
    logic [0:0]           grant_id;
    logic [15:0]          stall_cnt;
    logic [15:0]          err_cnt;

    regbank_write_arbiter #(
        .NUM_REQ(c_NR), .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .DEPTH(c_DP), .ZERO_RO(1)
    ) u_dut (
        .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .Rin(Rin), .we(we), .S(S), .grant_id(grant_id),
        .stall_cnt(stall_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] s;
        logic [31:0] rin;
        logic        gid;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_rr;
    logic [15:0] m_stall;
    logic [15:0] m_err;
    logic [31:0] m_rin;
    int          m_gid;
    logic [1:0]  m_ready;
    logic [15:0] r_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_stall = '0;
        m_err   = '0;
        m_rin   = '0;
        m_gid   = 0;
        m_ready = '0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic h);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        hold      = h;
    endtask

    // One cycle: predict at the falling edge, compare just after the rising edge.
    task automatic step();
        exp_t       e;
        int         win;
        bit         found;
        logic [4:0] a;
        #4;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < c_NR; k++) begin
            if (!found && req_valid[(m_rr + k) % c_NR]) begin
                found = 1'b1;
                win   = (m_rr + k) % c_NR;
            end
        end
        m_ready = (found && !hold) ? 2'(1 << win) : 2'b00;
        check("req_ready", 32'(req_ready), 32'(m_ready));
        if (|(req_valid & ~m_ready) && m_stall != 16'hFFFF) m_stall++;
        e.we = 1'b0;
        e.s  = '0;
        if (m_ready != 2'b00) begin
            m_rr = (win + 1) % c_NR;
            a    = req_addr[win*c_AW +: c_AW];
            if (a == 5'd0) begin
                e.we = 1'b0;
            end else if (a >= 5'(c_DP)) begin
                if (m_err != 16'hFFFF) m_err++;
            end else begin
                e.we  = 1'b1;
                e.s   = 16'(1) << a;
                m_rin = req_data[win*c_DW +: c_DW];
                m_gid = win;
            end
        end
        e.rin = m_rin;
        e.gid = m_gid[0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("we", 32'(we), 32'(e.we));
        check("S", 32'(S), 32'(e.s));
        check("Rin", Rin, e.rin);
        if (e.we) check("grant_id", 32'(grant_id), 32'(e.gid));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    initial begin
        reset = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        model_reset();
        #1 reset = 1'b1;
        #1 req_valid = 2'b11;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_S", 32'(S), 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;

        // idle after reset
        step();

        // single write from requester 0
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0);
        step();
        check("single_S", 32'(S), 32'h0000_0020);
        check("single_Rin", Rin, 32'hDEADBEEF);
        check("single_gid", 32'(grant_id), 32'h0);

        // requester 1 write returns rr_ptr to 0
        drive(2'b10, 5'd0, 32'd0, 5'd9, 32'h1234_5678, 1'b0);
        step();

        // contention: both held for 4 cycles
        r_base = stall_cnt;
        drive(2'b11, 5'd3, 32'hA0A0_A0A0, 5'd7, 32'hB1B1_B1B1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("contend_gid", 32'(grant_id), 32'(i % 2));
        end
        check("contend_stall", 32'(stall_cnt - r_base), 32'd4);

        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        step();

        // hold with requester 1 waiting
        r_base = stall_cnt;
        drive(2'b10, 5'd0, 32'd0, 5'd11, 32'hC0FF_EE11, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("hold_stall", 32'(stall_cnt - r_base), 32'd3);
        hold = 1'b0;
        step();
        check("hold_release_Rin", Rin, 32'hC0FF_EE11);
        check("hold_release_gid", 32'(grant_id), 32'h1);

        // rr_ptr back at 0: requester 0 wins a tie
        drive(2'b11, 5'd4, 32'h4444_4444, 5'd6, 32'h6666_6666, 1'b0);
        step();
        check("rr_wrap_gid", 32'(grant_id), 32'h0);
        drive(2'b10, 5'd4, 32'h4444_4444, 5'd6, 32'h6666_6666, 1'b0);
        step();

        // x0 write swallowed, out-of-range write counted
        r_base = err_cnt;
        drive(2'b01, 5'd0, 32'h0BAD_0000, 5'd0, 32'd0, 1'b0);
        step();
        check("x0_we", 32'(we), 32'h0);
        check("x0_err", 32'(err_cnt - r_base), 32'h0);
        drive(2'b01, 5'd20, 32'h0BAD_0020, 5'd0, 32'd0, 1'b0);
        step();
        check("oob_we", 32'(we), 32'h0);
        check("oob_err", 32'(err_cnt - r_base), 32'h1);

        // randomised traffic, addr/data stable until each requester transfers
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        m_ready = 2'b11;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < c_NR; i++) begin
                if (!req_valid[i] || m_ready[i]) begin
                    req_valid[i]            = 1'($urandom_range(0, 1));
                    req_addr[i*c_AW +: c_AW] = 5'($urandom_range(0, 31));
                    req_data[i*c_DW +: c_DW] = $urandom;
                end
            end
            hold = ($urandom_range(0, 3) == 0);
            step();
        end

        // reset right after a transfer edge discards the pending write
        drive(2'b01, 5'd2, 32'h2222_2222, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_we", 32'(we), 32'h0);
        check("midrst_S", 32'(S), 32'h0);
        check("midrst_Rin", Rin, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_next_we", 32'(we), 32'h0);
        reset = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        model_reset();
        step();

        // stall counter saturation
        drive(2'b01, 5'd1, 32'd1, 5'd0, 32'd0, 1'b1);
        repeat (70000) @(posedge clk);
        #1;
        check("sat_stall", 32'(stall_cnt), 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check("sat_stall_hold", 32'(stall_cnt), 32'h0000_FFFF);
        check("sat_ready", 32'(req_ready), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
